call_stack_ctrl: RTL and testbench
==================================

CALL_STACK_CTRL -- requirements
Module: call_stack_ctrl

Interface
REQ-001 Parameter: ADDR_W, default 8, width of one stored return address.
REQ-002 Parameter: DEPTH, default 8, number of entries; fixed at 8, and the pointer is 3 bits.
REQ-003 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port: rst  input  1  reset; synchronous, active-high.
REQ-005 Port: push  input  1  call request; store push_addr on top of the stack.
REQ-006 Port: pop  input  1  return request; remove the top entry.
REQ-007 Port: push_addr  input  ADDR_W  return address to store.
REQ-008 Port: clear_fault  input  1  leave the FAULT state.
REQ-009 Port: top_addr  output  ADDR_W  registered copy of the current top entry; 0 when empty.
REQ-010 Port: sp  output  3  index of the top entry, equal to (depth-1) mod 8.
REQ-011 Port: depth  output  4  number of valid entries, 0..8.
REQ-012 Port: empty / full  output  1 each  empty is high when depth==0; full is high when depth==8.
REQ-013 Port: ack  output  1  one-cycle pulse in the cycle after an operation is accepted.
REQ-014 Port: fault  output  1  high while in the FAULT state.
REQ-015 Port: fault_code  output  2  00 none, 01 overflow, 10 underflow; holds its value until cleared.

Function
REQ-016 States: RUN and FAULT; rst enters RUN.
REQ-017 In RUN, an operation (push|pop) is accepted in the cycle it is sampled; there is no stall and no request hold.
REQ-018 Push only, !full: write mem[depth[2:0]] with push_addr, depth+1, top_addr=push_addr next cycle, ack next cycle.
REQ-019 Pop only, !empty: depth-1; the next top_addr is mem[depth-2], or 0 if the new depth is 0; ack next cycle.
REQ-020 Push and pop together, !empty: replace the top entry with push_addr, depth unchanged, top_addr=push_addr, ack next cycle.
REQ-021 Push and pop together, empty: treated as push only.
REQ-022 Push only, full: no write, state unchanged, go to FAULT with fault_code=01, no ack.
REQ-023 Pop only, empty: state unchanged, go to FAULT with fault_code=10, no ack.
REQ-024 Push and pop together while full: treated as a replace (REQ-020); no overflow.
REQ-025 In FAULT, push and pop are ignored; contents and depth are retained; ack stays low.
REQ-026 clear_fault in FAULT: next state RUN, fault_code=00; a push/pop sampled in the same cycle is ignored.
REQ-027 clear_fault in RUN has no effect.
REQ-028 The pointer is modulo 8; depth saturates at 0..8 and never wraps.
REQ-029 All outputs are registered or derived directly from registered depth; there is no combinational path from inputs to outputs.

Reset
REQ-030 rst sampled high: depth=0, sp=7, top_addr=0, empty=1, full=0, ack=0, fault=0, fault_code=00, state RUN.
REQ-031 rst overrides push, pop and clear_fault in the same cycle.
REQ-032 rst during FAULT or mid-sequence aborts any pending ack.
REQ-033 Memory contents are not reset; only depth determines validity.

Structure
REQ-034 Shared package: state enum {RUN, FAULT}, fault_code constants FC_NONE/FC_OVF/FC_UNF, DEPTH constant.
REQ-035 One sub-module, stack_ram: 8 x ADDR_W registers, one synchronous write port, one asynchronous read port.
REQ-036 Control, depth and fault logic stay in call_stack_ctrl.

Verification
REQ-037 Basic push/pop: after rst, push 0x11, 0x22, 0x33 -> depth 3, sp 2, top_addr 0x33; ack pulses once per push. Pop -> top_addr 0x22, depth 2.
REQ-038 Overflow: 8 pushes 0x01..0x08 -> full=1, top 0x08. A 9th push -> fault=1, fault_code=01, depth 8, top 0x08, no ack.
REQ-039 Underflow and recovery: pop when empty -> fault_code=10. A push in FAULT is ignored (depth 0). clear_fault -> fault=0; a subsequent push 0x44 is accepted.
REQ-040 Simultaneous ops: push+pop at depth 3 with 0x55 -> depth 3, top 0x55. Push+pop at depth 0 with 0x66 -> depth 1, top 0x66. Push+pop at depth 8 -> no fault.
REQ-041 Reset mid-operation: rst asserted in the same cycle as a push at depth 5 -> depth 0, ack 0, top 0.
REQ-042 Random push/pop sequence checked against a reference model; no ack is ever issued in FAULT.

Source files
------------

// File: rtl/call_stack_ctrl_pkg.sv
// rtl/call_stack_ctrl_pkg.sv - shared types and constants for the call stack controller
package call_stack_ctrl_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FAULT = 1'b1
    } state_t;

    localparam logic [1:0] FC_NONE = 2'b00;
    localparam logic [1:0] FC_OVF  = 2'b01;
    localparam logic [1:0] FC_UNF  = 2'b10;

    localparam int STACK_DEPTH = 8;
    localparam int PTR_W       = 3;

endpackage

// File: rtl/call_stack_ctrl_if.sv
// rtl/call_stack_ctrl_if.sv - request/status bundle between a caller and the call stack
interface call_stack_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] push_addr;
    logic              clear_fault;
    logic [ADDR_W-1:0] top_addr;
    logic [2:0]        sp;
    logic [3:0]        depth;
    logic              empty;
    logic              full;
    logic              ack;
    logic              fault;
    logic [1:0]        fault_code;

    modport master (
        output push, pop, push_addr, clear_fault,
        input  top_addr, sp, depth, empty, full, ack, fault, fault_code
    );

    modport slave (
        input  push, pop, push_addr, clear_fault,
        output top_addr, sp, depth, empty, full, ack, fault, fault_code
    );
endinterface

// File: rtl/call_stack_ctrl_stack_ram.sv
// rtl/call_stack_ctrl_stack_ram.sv - 8-entry register file, sync write, async read
module stack_ram
    import call_stack_ctrl_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  logic [ADDR_W-1:0] wdata,
    input  logic [PTR_W-1:0]  raddr,
    output logic [ADDR_W-1:0] rdata
);

    // No reset: entry validity is tracked solely by the controller's depth.
    logic [ADDR_W-1:0] mem [STACK_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/call_stack_ctrl.sv
// rtl/call_stack_ctrl.sv - return-address stack with overflow/underflow fault handling
module call_stack_ctrl
    import call_stack_ctrl_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 8
) (
    input  logic             clk,
    input  logic             rst,
    call_stack_ctrl_if.slave bus
);

    state_t            state_q, state_d;
    logic [3:0]        depth_q, depth_d;
    logic [ADDR_W-1:0] top_q, top_d;
    logic              ack_q, ack_d;
    logic [1:0]        fc_q, fc_d;

    logic              we;
    logic [PTR_W-1:0]  waddr;
    logic [PTR_W-1:0]  raddr;
    logic [ADDR_W-1:0] rdata;
    logic              is_empty;
    logic              is_full;
    logic [PTR_W-1:0]  top_idx;

    assign is_empty = (depth_q == 4'd0);
    assign is_full  = (depth_q == 4'(DEPTH));
    assign top_idx  = depth_q[PTR_W-1:0] - 3'd1;
    // Entry that becomes the top after a pop; wraps harmlessly when depth is 0 or 1.
    assign raddr    = depth_q[PTR_W-1:0] - 3'd2;

    stack_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (bus.push_addr),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            depth_q <= 4'd0;
            top_q   <= '0;
            ack_q   <= 1'b0;
            fc_q    <= FC_NONE;
        end else begin
            state_q <= state_d;
            depth_q <= depth_d;
            top_q   <= top_d;
            ack_q   <= ack_d;
            fc_q    <= fc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        depth_d = depth_q;
        top_d   = top_q;
        ack_d   = 1'b0;
        fc_d    = fc_q;
        we      = 1'b0;
        waddr   = depth_q[PTR_W-1:0];
        unique case (state_q)
            ST_RUN: begin
                if (bus.push && bus.pop && !is_empty) begin
                    we    = 1'b1;
                    waddr = top_idx;
                    top_d = bus.push_addr;
                    ack_d = 1'b1;
                end else if (bus.push) begin
                    if (!is_full) begin
                        we      = 1'b1;
                        depth_d = depth_q + 4'd1;
                        top_d   = bus.push_addr;
                        ack_d   = 1'b1;
                    end else begin
                        state_d = ST_FAULT;
                        fc_d    = FC_OVF;
                    end
                end else if (bus.pop) begin
                    if (!is_empty) begin
                        depth_d = depth_q - 4'd1;
                        top_d   = (depth_q == 4'd1) ? '0 : rdata;
                        ack_d   = 1'b1;
                    end else begin
                        state_d = ST_FAULT;
                        fc_d    = FC_UNF;
                    end
                end
            end
            ST_FAULT: begin
                if (bus.clear_fault) begin
                    state_d = ST_RUN;
                    fc_d    = FC_NONE;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    assign bus.top_addr   = top_q;
    assign bus.sp         = top_idx;
    assign bus.depth      = depth_q;
    assign bus.empty      = is_empty;
    assign bus.full       = is_full;
    assign bus.ack        = ack_q;
    assign bus.fault      = (state_q == ST_FAULT);
    assign bus.fault_code = fc_q;

endmodule

// File: tb/tb_call_stack_ctrl.sv
// tb/tb_call_stack_ctrl.sv - vector table plus scoreboarded random run for call_stack_ctrl
module tb_call_stack_ctrl;

    typedef struct {
        bit       rst, push, pop, clr;
        bit [7:0] addr;
        int       e_depth;
        bit [7:0] e_top;
        bit       e_ack, e_fault;
        bit [1:0] e_fc;
    } vec_t;

    typedef struct {
        int       depth;
        bit [7:0] top;
        bit       ack, fault;
        bit [1:0] fc;
        bit [2:0] sp;
        bit       empty, full;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    call_stack_ctrl_if #(.ADDR_W(8)) bus ();

    call_stack_ctrl #(.ADDR_W(8), .DEPTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int nchecks = 0;
    int nerr    = 0;

    vec_t vecs[$];
    exp_t sb[$];

    bit [7:0] m_mem [8];
    int       m_depth;
    bit [7:0] m_top;
    bit       m_ack, m_fault;
    bit [1:0] m_fc;

    task automatic check(input string name, input int act, input int exp);
        nchecks++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input bit r, p, o, c, input bit [7:0] a,
                           input int d, input bit [7:0] t, input bit k, f, input bit [1:0] fc);
        vec_t v;
        v.rst = r; v.push = p; v.pop = o; v.clr = c; v.addr = a;
        v.e_depth = d; v.e_top = t; v.e_ack = k; v.e_fault = f; v.e_fc = fc;
        vecs.push_back(v);
    endtask

    task automatic model_step(input bit r, p, o, c, input bit [7:0] a);
        if (r) begin
            m_depth = 0; m_top = 0; m_ack = 0; m_fault = 0; m_fc = 0;
        end else if (m_fault) begin
            m_ack = 0;
            if (c) begin
                m_fault = 0; m_fc = 0;
            end
        end else begin
            m_ack = 0;
            if (p && o && m_depth != 0) begin
                m_mem[m_depth-1] = a; m_top = a; m_ack = 1;
            end else if (p) begin
                if (m_depth < 8) begin
                    m_mem[m_depth] = a; m_depth++; m_top = a; m_ack = 1;
                end else begin
                    m_fault = 1; m_fc = 2'b01;
                end
            end else if (o) begin
                if (m_depth > 0) begin
                    m_depth--;
                    m_top = (m_depth == 0) ? 8'h00 : m_mem[m_depth-1];
                    m_ack = 1;
                end else begin
                    m_fault = 1; m_fc = 2'b10;
                end
            end
        end
    endtask

    // Drive one cycle, queue the model's prediction, then compare after the edge.
    task automatic cycle(input bit r, p, o, c, input bit [7:0] a);
        exp_t e;
        rst = r; bus.push = p; bus.pop = o; bus.clear_fault = c; bus.push_addr = a;
        model_step(r, p, o, c, a);
        e.depth = m_depth; e.top = m_top; e.ack = m_ack; e.fault = m_fault; e.fc = m_fc;
        e.sp = 3'(m_depth - 1); e.empty = (m_depth == 0); e.full = (m_depth == 8);
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check("sb_depth", int'(bus.depth), e.depth);
        check("sb_top", int'(bus.top_addr), int'(e.top));
        check("sb_ack", int'(bus.ack), int'(e.ack));
        check("sb_fault", int'(bus.fault), int'(e.fault));
        check("sb_fc", int'(bus.fault_code), int'(e.fc));
        check("sb_sp", int'(bus.sp), int'(e.sp));
        check("sb_empty", int'(bus.empty), int'(e.empty));
        check("sb_full", int'(bus.full), int'(e.full));
    endtask

    initial begin
        rst = 1'b1; bus.push = 0; bus.pop = 0; bus.clear_fault = 0; bus.push_addr = 0;

        // basic push/pop and simultaneous ops
        add_vec(1,0,0,0,8'h00, 0,8'h00,0,0,2'd0);
        add_vec(0,1,0,0,8'h11, 1,8'h11,1,0,2'd0);
        add_vec(0,1,0,0,8'h22, 2,8'h22,1,0,2'd0);
        add_vec(0,1,0,0,8'h33, 3,8'h33,1,0,2'd0);
        add_vec(0,0,1,0,8'h00, 2,8'h22,1,0,2'd0);
        add_vec(0,0,0,0,8'h00, 2,8'h22,0,0,2'd0);
        add_vec(0,1,0,0,8'h33, 3,8'h33,1,0,2'd0);
        add_vec(0,1,1,0,8'h55, 3,8'h55,1,0,2'd0);
        add_vec(0,0,1,0,8'h00, 2,8'h22,1,0,2'd0);
        add_vec(1,0,0,0,8'h00, 0,8'h00,0,0,2'd0);
        add_vec(0,1,1,0,8'h66, 1,8'h66,1,0,2'd0);
        add_vec(1,0,0,0,8'h00, 0,8'h00,0,0,2'd0);
        // overflow, fault hold, clear, replace at full
        for (int i = 1; i <= 8; i++) add_vec(0,1,0,0,8'(i), i,8'(i),1,0,2'd0);
        add_vec(0,1,0,0,8'h09, 8,8'h08,0,1,2'd1);
        add_vec(0,1,0,0,8'h0a, 8,8'h08,0,1,2'd1);
        add_vec(0,1,0,1,8'h0b, 8,8'h08,0,0,2'd0);
        add_vec(0,1,1,0,8'h77, 8,8'h77,1,0,2'd0);
        add_vec(0,0,1,0,8'h00, 7,8'h07,1,0,2'd0);
        // underflow and recovery
        add_vec(1,0,0,0,8'h00, 0,8'h00,0,0,2'd0);
        add_vec(0,0,1,0,8'h00, 0,8'h00,0,1,2'd2);
        add_vec(0,1,0,0,8'h99, 0,8'h00,0,1,2'd2);
        add_vec(0,0,0,1,8'h00, 0,8'h00,0,0,2'd0);
        add_vec(0,1,0,0,8'h44, 1,8'h44,1,0,2'd0);
        add_vec(0,0,0,1,8'h00, 1,8'h44,0,0,2'd0);
        // reset colliding with a push at depth 5
        for (int i = 2; i <= 5; i++) add_vec(0,1,0,0,8'(8'ha0 + i), i,8'(8'ha0 + i),1,0,2'd0);
        add_vec(1,1,0,0,8'hbb, 0,8'h00,0,0,2'd0);
        add_vec(0,0,0,0,8'h00, 0,8'h00,0,0,2'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].rst, vecs[i].push, vecs[i].pop, vecs[i].clr, vecs[i].addr);
            check($sformatf("vec%0d_depth", i), int'(bus.depth), vecs[i].e_depth);
            check($sformatf("vec%0d_top", i), int'(bus.top_addr), int'(vecs[i].e_top));
            check($sformatf("vec%0d_ack", i), int'(bus.ack), int'(vecs[i].e_ack));
            check($sformatf("vec%0d_fault", i), int'(bus.fault), int'(vecs[i].e_fault));
            check($sformatf("vec%0d_fc", i), int'(bus.fault_code), int'(vecs[i].e_fc));
        end

        // sp after reset must be 7
        cycle(1,0,0,0,8'h00);
        check("reset_sp", int'(bus.sp), 7);

        // ack pending from a push is killed by reset in the next cycle
        cycle(0,1,0,0,8'h12);
        check("push_ack", int'(bus.ack), 1);
        cycle(1,0,0,0,8'h00);
        check("reset_kills_ack", int'(bus.ack), 0);

        for (int i = 0; i < 400; i++) begin
            bit r, p, o, c;
            r = ($urandom_range(0, 59) == 0);
            p = ($urandom_range(0, 99) < 55);
            o = ($urandom_range(0, 99) < 45);
            c = ($urandom_range(0, 9) == 0);
            cycle(r, p, o, c, 8'($urandom));
            check("ack_in_fault", int'(bus.ack & bus.fault), 0);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
